// File: rtl/debounce_timer_arbiter.sv
// Round-robin arbiter sharing one settle-interval timer among N_CH debounce channels.
// Outputs are decoded from registered state only; req never reaches an output combinationally.
module debounce_timer_arbiter #(
    parameter int N_CH      = 4,
    parameter int COUNT_MAX = 20,
    parameter int CNT_W     = $clog2(COUNT_MAX),
    parameter int ID_W      = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   req,
    output logic [N_CH-1:0]   grant,
    output logic [N_CH-1:0]   done,
    output logic              busy,
    output logic [ID_W-1:0]   owner
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TIMING = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

    logic [1:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  next_ptr;
    logic [ID_W-1:0]  pick;
    logic             pick_valid;
    logic [CNT_W-1:0] cnt;

    // Explicit wrap keeps non-power-of-two channel counts in range.
    always_comb begin
        next_ptr = (owner == LAST_ID) ? '0 : owner + ID_W'(1);
    end

    // First requesting channel at or after ptr, wrapping modulo N_CH.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        cand       = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = int'(ptr) + int'(i);
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            cand = ID_W'(idx);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick;
                        cnt   <= '0;
                        state <= TIMING;
                    end
                end
                TIMING: begin
                    // Abort outranks expiry on the final count.
                    if (!req[owner]) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= next_ptr;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        grant = '0;
        done  = '0;
        busy  = (state != IDLE);
        if (busy) begin
            grant[owner] = 1'b1;
        end
        if (state == DONE) begin
            done[owner] = 1'b1;
        end
    end

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Scoreboard bench: the driver pushes per-cycle expectations from an edge-counting
// reference model; a negedge monitor pops and compares them against the DUT outputs.
module tb_debounce_timer_arbiter;

    localparam int N_CH      = 4;
    localparam int COUNT_MAX = 8;
    localparam int ID_W      = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] req = '0;
    logic [N_CH-1:0] grant;
    logic [N_CH-1:0] done;
    logic            busy;
    logic [ID_W-1:0] owner;

    debounce_timer_arbiter #(
        .N_CH      (N_CH),
        .COUNT_MAX (COUNT_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH-1:0] grant;
        logic [N_CH-1:0] done;
        logic            busy;
        logic [ID_W-1:0] owner;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mon_cyc = 0;

    // Reference model: timing expressed as absolute edge numbers relative to the grant edge.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_grant_edge;
    int edge_n = 0;

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
    endfunction

    function automatic void model_edge(input logic [N_CH-1:0] r);
        int age;
        int c;
        edge_n++;
        if (m_busy) begin
            age = edge_n - m_grant_edge;
            if (age == COUNT_MAX + 1) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N_CH;
            end else if (!r[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N_CH;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                c = (m_ptr + i) % N_CH;
                if (!m_busy && r[c]) begin
                    m_busy       = 1'b1;
                    m_owner      = c;
                    m_grant_edge = edge_n;
                end
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.busy  = m_busy;
        e.owner = ID_W'(m_owner);
        e.grant = m_busy ? (N_CH'(1) << m_owner) : '0;
        e.done  = (m_busy && (edge_n - m_grant_edge == COUNT_MAX)) ? (N_CH'(1) << m_owner) : '0;
        return e;
    endfunction

    function automatic exp_t zeros();
        exp_t e;
        e.grant = '0;
        e.done  = '0;
        e.busy  = 1'b0;
        e.owner = '0;
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, mon_cyc, got, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        mon_cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("grant", int'(grant), int'(e.grant));
            chk("done",  int'(done),  int'(e.done));
            chk("busy",  int'(busy),  int'(e.busy));
            chk("owner", int'(owner), int'(e.owner));
        end
    end

    // Called from just after a negedge; one clock edge per call.
    task automatic step(input logic [N_CH-1:0] v);
        req = v;
        @(posedge clk);
        model_edge(v);
        sb.push_back(model_out());
        @(negedge clk);
        #1;
    endtask

    // Reset lands between posedge and negedge, so the negedge check sees its asynchronous effect.
    task automatic do_reset();
        @(posedge clk);
        model_edge(req);
        #1;
        reset = 1'b1;
        model_reset();
        sb.push_back(zeros());
        @(negedge clk);
        #1;
        repeat (2) begin
            @(posedge clk);
            sb.push_back(zeros());
            @(negedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        logic [N_CH-1:0] r;
        model_reset();
        @(negedge clk);
        #1;
        do_reset();

        // Single channel, full interval.
        repeat (14) step(4'b0001);
        repeat (3)  step(4'b0000);

        // All channels requesting: rotation 0,1,2,3,0.
        do_reset();
        repeat (48) step(4'b1111);
        step(4'b0000);

        // Abort after 3 timing cycles with channel 2 pending.
        do_reset();
        repeat (4)  step(4'b0010);
        repeat (12) step(4'b0100);
        step(4'b0000);

        // Owner drops on the final-count edge.
        do_reset();
        repeat (8) step(4'b0001);
        repeat (3) step(4'b0000);

        // Reset mid-interval, then a clean interval from zero.
        do_reset();
        repeat (4) step(4'b0001);
        do_reset();
        repeat (12) step(4'b0001);
        step(4'b0000);

        // Pointer wraps from channel 3 back to 0.
        do_reset();
        repeat (9)  step(4'b1000);
        repeat (12) step(4'b1001);
        step(4'b0000);

        // Random request toggling with occasional reset.
        r = '0;
        repeat (2500) begin
            for (int b = 0; b < N_CH; b++) begin
                if ($urandom_range(0, 15) == 0) begin
                    r[b] = ~r[b];
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            step(r);
        end

        @(negedge clk);
        #1;
        chk("drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
